// File: rtl/kmac_pkg.sv
// Shared KMAC/Keccak absorb definitions: rate presets, suffix/pad bytes and FSM encoding.
package kmac_pkg;

    localparam int unsigned RATE_KMAC128 = 168;
    localparam int unsigned RATE_KMAC256 = 136;

    localparam logic [7:0] DS_CSHAKE = 8'h04;
    localparam logic [7:0] DS_SHA3   = 8'h06;
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [2:0] {
        KA_IDLE       = 3'd0,
        KA_ABSORB     = 3'd1,
        KA_ISSUE      = 3'd2,
        KA_PAD        = 3'd3,
        KA_ISSUE_LAST = 3'd4,
        KA_DONE       = 3'd5
    } kmac_absorb_state_e;

endpackage

// File: rtl/kmac_absorb_ctrl.sv
// Byte-stream sponge absorb sequencer: packs bytes into rate blocks, applies pad10*1 with
// domain suffix on the final block and hands blocks to the permutation via valid/ready.
module kmac_absorb_ctrl
    import kmac_pkg::*;
#(
    parameter int unsigned RATE_BYTES = RATE_KMAC256,
    parameter logic [7:0]  DS_BYTE    = DS_CSHAKE,
    parameter int unsigned POS_W      = $clog2(RATE_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_keep,
    input  logic                    in_last,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [RATE_BYTES*8-1:0] blk_data,
    output logic                    blk_last,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned      BLK_W    = RATE_BYTES * 8;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(RATE_BYTES - 1);

    localparam logic [2:0] ST_IDLE       = KA_IDLE;
    localparam logic [2:0] ST_ABSORB     = KA_ABSORB;
    localparam logic [2:0] ST_ISSUE      = KA_ISSUE;
    localparam logic [2:0] ST_PAD        = KA_PAD;
    localparam logic [2:0] ST_ISSUE_LAST = KA_ISSUE_LAST;
    localparam logic [2:0] ST_DONE       = KA_DONE;

    logic [2:0]       state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             pad_pend_q, pad_pend_d;

    logic in_ready_q, blk_valid_q, blk_last_q, busy_q, done_q;

    // Next-state, byte write and padding update
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        blk_d      = blk_q;
        pad_pend_d = pad_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ABSORB;
                    pos_d   = '0;
                    blk_d   = '0;
                end
            end

            ST_ABSORB: begin
                if (in_valid && in_ready_q) begin
                    if (in_keep) begin
                        blk_d[{pos_q, 3'b000} +: 8] = in_data;
                        if (pos_q == POS_LAST) begin
                            // Full block; a coincident last byte needs a trailing pad-only block
                            state_d    = ST_ISSUE;
                            pad_pend_d = in_last;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                            if (in_last) begin
                                state_d = ST_PAD;
                            end
                        end
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end

            ST_ISSUE: begin
                if (blk_ready) begin
                    blk_d      = '0;
                    pos_d      = '0;
                    pad_pend_d = 1'b0;
                    state_d    = pad_pend_q ? ST_PAD : ST_ABSORB;
                end
            end

            ST_PAD: begin
                // XOR form lets both terms merge into 0x84 when pos is the last byte
                blk_d[{pos_q, 3'b000} +: 8] = blk_d[{pos_q, 3'b000} +: 8] ^ DS_BYTE;
                blk_d[BLK_W-1 -: 8]         = blk_d[BLK_W-1 -: 8] ^ PAD_LAST;
                state_d                     = ST_ISSUE_LAST;
            end

            ST_ISSUE_LAST: begin
                if (blk_ready) begin
                    blk_d   = '0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output decode of the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            blk_q       <= '0;
            pad_pend_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            blk_q       <= blk_d;
            pad_pend_q  <= pad_pend_d;
            in_ready_q  <= (state_d == ST_ABSORB);
            blk_valid_q <= (state_d == ST_ISSUE) || (state_d == ST_ISSUE_LAST);
            blk_last_q  <= (state_d == ST_ISSUE_LAST);
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign blk_valid = blk_valid_q;
    assign blk_last  = blk_last_q;
    assign blk_data  = blk_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_kmac_absorb_ctrl.sv
// Directed bench for kmac_absorb_ctrl: table of messages checked against an independent
// pad10*1 model, plus hand sequences for latency, ignored start, and async reset.
module tb_kmac_absorb_ctrl;

    localparam int RB = 136;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_keep = 1'b0;
    logic          in_last = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          blk_ready = 1'b0;
    logic          in_ready, blk_valid, blk_last, busy, done;
    logic [RB*8-1:0] blk_data;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] pm [4*RB];

    typedef struct {
        int         len;
        logic [7:0] seed;
        bit         tail;
        bit         junk;
        int         bp;
        int         nblk;
    } vec_t;

    vec_t vecs [8];

    kmac_absorb_ctrl #(
        .RATE_BYTES (RB),
        .DS_BYTE    (8'h04)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_keep   (in_keep),
        .in_last   (in_last),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic chk_blk(input string name, input logic [RB*8-1:0] got, input logic [RB*8-1:0] exp);
        int bad;
        bad = -1;
        n_total++;
        for (int j = RB - 1; j >= 0; j--) begin
            if (got[8*j +: 8] !== exp[8*j +: 8]) bad = j;
        end
        if (bad < 0) n_pass++;
        else $display("FAIL %s: byte %0d got %02h expected %02h", name, bad,
                      got[8*bad +: 8], exp[8*bad +: 8]);
    endtask

    function automatic logic [7:0] msg_byte(input logic [7:0] seed, input int i);
        return seed + 8'(i * 17);
    endfunction

    // Reference padded message: data, suffix at byte len, 0x80 into the last byte of the last block
    task automatic build_model(input int len, input logic [7:0] seed, input int nblk);
        for (int i = 0; i < 4 * RB; i++) pm[i] = 8'h00;
        for (int i = 0; i < len; i++) pm[i] = msg_byte(seed, i);
        pm[len]          = pm[len] ^ 8'h04;
        pm[nblk*RB - 1]  = pm[nblk*RB - 1] ^ 8'h80;
    endtask

    function automatic logic [RB*8-1:0] exp_block(input int k);
        logic [RB*8-1:0] v;
        for (int j = 0; j < RB; j++) v[8*j +: 8] = pm[k*RB + j];
        return v;
    endfunction

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic drive_msg(input int len, input logic [7:0] seed, input bit tail, input bit junk);
        logic [9:0] q [$];
        int idx;
        int guard;
        idx   = 0;
        guard = 0;
        for (int i = 0; i < len; i++) begin
            if (junk && (i % 5 == 2)) q.push_back({1'b0, 1'b0, 8'hEE});
            q.push_back({1'b1, 1'(!tail && (i == len - 1)), msg_byte(seed, i)});
        end
        if (tail) q.push_back({1'b0, 1'b1, 8'h5A});
        while (idx < q.size() && guard < 5000) begin
            @(negedge clk);
            in_valid = 1'b1;
            {in_keep, in_last, in_data} = q[idx];
            if (in_ready) idx++;
            guard++;
        end
        if (idx < q.size()) fail_now("drive");
        @(negedge clk);
        in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
    endtask

    task automatic collect(input string name, input int nblk, input int bp);
        int got, wait_c, guard;
        bit stable, inr_low;
        logic [RB*8-1:0] held;
        got = 0; wait_c = 0; guard = 0; stable = 1'b1; inr_low = 1'b1; held = '0;
        while (got < nblk && guard < 5000) begin
            @(negedge clk);
            blk_ready = 1'b0;
            guard++;
            if (blk_valid) begin
                if (wait_c == 0) held = blk_data;
                else if (blk_data !== held) stable = 1'b0;
                if (in_ready) inr_low = 1'b0;
                if (wait_c < bp) begin
                    wait_c++;
                end else begin
                    chk_blk($sformatf("%s_blk%0d", name, got), blk_data, exp_block(got));
                    chk($sformatf("%s_last%0d", name, got), 64'(blk_last), 64'(got == nblk - 1));
                    if (bp > 0) begin
                        chk($sformatf("%s_stable%0d", name, got), 64'(stable), 64'(1));
                        chk($sformatf("%s_inrdy_low%0d", name, got), 64'(inr_low), 64'(1));
                    end
                    blk_ready = 1'b1;
                    got++; wait_c = 0; stable = 1'b1; inr_low = 1'b1;
                end
            end
        end
        if (got < nblk) fail_now({name, "_collect"});
    endtask

    task automatic run_vec(input vec_t v, input string name);
        build_model(v.len, v.seed, v.nblk);
        do_start();
        fork
            drive_msg(v.len, v.seed, v.tail, v.junk);
            collect(name, v.nblk, v.bp);
        join
        @(negedge clk); blk_ready = 1'b0;
        chk({name, "_done"}, 64'({done, blk_valid}), 64'(2'b10));
        @(negedge clk);
        chk({name, "_idle"}, 64'({done, busy}), 64'(2'b00));
    endtask

    initial begin
        logic [RB*8-1:0] snap;
        bit all_rdy;

        //          len  seed   tail junk bp  nblk
        vecs[0] = '{0,   8'h00, 1,   0,   0,  1};
        vecs[1] = '{3,   8'hAA, 0,   0,   0,  1};
        vecs[2] = '{135, 8'h01, 0,   1,   0,  1};
        vecs[3] = '{136, 8'h02, 0,   0,   0,  2};
        vecs[4] = '{136, 8'h03, 1,   0,   2,  2};
        vecs[5] = '{137, 8'h04, 0,   0,   0,  2};
        vecs[6] = '{300, 8'h05, 0,   1,   10, 3};
        vecs[7] = '{272, 8'h06, 1,   0,   1,  3};

        #12;
        chk("reset_outs", 64'({in_ready, blk_valid, blk_last, busy, done}), 64'(0));
        chk("reset_blk_zero", 64'(blk_data == '0), 64'(1));
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outs", 64'({in_ready, blk_valid, busy}), 64'(0));

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Final-byte latency: last accepted in N, PAD in N+1, blk_valid in N+2
        build_model(3, 8'hAA, 1);
        do_start();
        @(negedge clk); in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b0; in_data = 8'hAA;
        @(negedge clk); in_data = 8'hBB;
        @(negedge clk); in_data = 8'hCC; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
        chk("lat_pad_cycle", 64'({blk_valid, in_ready, busy}), 64'(3'b001));
        @(negedge clk);
        chk("lat_valid_cycle", 64'({blk_valid, blk_last}), 64'(2'b11));
        chk_blk("lat_blk", blk_data, exp_block(0));
        blk_ready = 1'b1;
        @(negedge clk); blk_ready = 1'b0;
        chk("lat_done", 64'(done), 64'(1));
        @(negedge clk);

        // Full block issues next cycle; start during ISSUE is ignored
        build_model(136, 8'h30, 2);
        do_start();
        all_rdy = 1'b1;
        for (int i = 0; i < RB; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b0; in_data = msg_byte(8'h30, i);
            if (!in_ready) all_rdy = 1'b0;
        end
        @(negedge clk); in_valid = 1'b0; in_keep = 1'b0; start = 1'b1;
        chk("full_rdy_all", 64'(all_rdy), 64'(1));
        chk("full_issue", 64'({blk_valid, blk_last, in_ready}), 64'(3'b100));
        chk_blk("full_blk0", blk_data, exp_block(0));
        snap = blk_data;
        @(negedge clk); start = 1'b0;
        chk("start_ignored", 64'({blk_valid, busy, in_ready}), 64'(3'b110));
        chk("start_ignored_data", 64'(blk_data === snap), 64'(1));
        blk_ready = 1'b1;
        @(negedge clk); blk_ready = 1'b0;
        chk("full_back_absorb", 64'({in_ready, blk_valid}), 64'(2'b10));
        in_valid = 1'b1; in_keep = 1'b0; in_last = 1'b1;
        @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("tail_issue", 64'({blk_valid, blk_last}), 64'(2'b11));
        chk_blk("tail_blk1", blk_data, exp_block(1));
        blk_ready = 1'b1;
        @(negedge clk); blk_ready = 1'b0;
        chk("tail_done", 64'(done), 64'(1));
        @(negedge clk);

        // Async reset while absorbing at pos 50, then a clean message must not see stale bytes
        do_start();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_keep = 1'b1; in_last = 1'b0; in_data = 8'hFF;
        end
        @(negedge clk); in_valid = 1'b0; in_keep = 1'b0;
        chk("pre_rst_busy", 64'({busy, in_ready}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outs", 64'({in_ready, blk_valid, blk_last, busy, done}), 64'(0));
        chk("async_rst_blk", 64'(blk_data == '0), 64'(1));
        @(negedge clk); rst_n = 1'b1;
        run_vec('{3, 8'h11, 0, 0, 0, 1}, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
